// File: rtl/hamming_receptor_serie.sv
// Serial Hamming(7,4) receiver: collects 7-bit frames MSB first, corrects
// single-bit errors and hands the data nibble to a valid/ready consumer.
module hamming_receptor_serie (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_bit,
    input  logic       rx_valid,
    input  logic       rx_sof,
    output logic [3:0] d_out,
    output logic [2:0] sindrome,
    output logic       corregido,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] err_count
);

    localparam int unsigned CW_W   = 7;
    localparam int unsigned SYN_W  = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ERRC_W = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CW_W - 1);
    localparam logic [ERRC_W-1:0] ERRC_MAX = '1;

    logic [0:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CW_W-1:0]  shreg, shreg_nx;
    logic             frame_done_c;

    logic [CW_W-1:0]  chk_reg;
    logic             chk_pend;
    logic [SYN_W-1:0] syn_c;
    logic [CW_W-1:0]  fix_mask_c;
    logic [CW_W-1:0]  fixed_c;
    logic             load_c;

    // Receive FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
        end
    end

    // Next-state: start on sof, shift bits in, flag the 7th bit
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        shreg_nx     = shreg;
        frame_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_sof) begin
                    shreg_nx = CW_W'(rx_bit);
                    cnt_nx   = CNT_W'(1);
                    state_nx = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        // A new sof abandons the partial frame
                        shreg_nx = CW_W'(rx_bit);
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        shreg_nx = {shreg[CW_W-2:0], rx_bit};
                        if (cnt == LAST_BIT) begin
                            frame_done_c = 1'b1;
                            cnt_nx       = '0;
                            state_nx     = IDLE;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Check stage: latch the complete codeword for one syndrome cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg  <= '0;
            chk_pend <= 1'b0;
        end else begin
            if (frame_done_c) begin
                chk_reg <= shreg_nx;
            end
            chk_pend <= frame_done_c;
        end
    end

    // Syndrome and single-bit correction of the checked codeword
    always_comb begin
        syn_c[2]   = chk_reg[6] ^ chk_reg[5] ^ chk_reg[4] ^ chk_reg[3];
        syn_c[1]   = chk_reg[6] ^ chk_reg[5] ^ chk_reg[2] ^ chk_reg[1];
        syn_c[0]   = chk_reg[6] ^ chk_reg[4] ^ chk_reg[2] ^ chk_reg[0];
        fix_mask_c = '0;
        if (syn_c != '0) begin
            fix_mask_c = CW_W'(1) << (syn_c - SYN_W'(1));
        end
        fixed_c = chk_reg ^ fix_mask_c;
        load_c  = chk_pend && (!out_valid || out_ready);
    end

    // Output stage: valid/ready holding register, overflow and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out     <= '0;
            sindrome  <= '0;
            corregido <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (load_c) begin
                d_out     <= {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
                sindrome  <= syn_c;
                corregido <= (syn_c != '0);
                out_valid <= 1'b1;
                if ((syn_c != '0) && (err_count != ERRC_MAX)) begin
                    err_count <= err_count + ERRC_W'(1);
                end
            end else begin
                if (chk_pend) begin
                    // Output still owned by the consumer: the new word is lost
                    overflow <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hamming_receptor_serie.sv
// Scoreboard bench for hamming_receptor_serie: stimulus pushes expected words,
// a monitor pops them on each accepted output.
module tb_hamming_receptor_serie;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_bit, rx_valid, rx_sof;
    logic [3:0] d_out;
    logic [2:0] sindrome;
    logic       corregido, out_valid, out_ready, overflow;
    logic [7:0] err_count;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_err  = 0;

    hamming_receptor_serie dut (
        .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .d_out(d_out), .sindrome(sindrome),
        .corregido(corregido), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every accepted word is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_word: got d=%b s=%b c=%b, expected none",
                         d_out, sindrome, corregido);
            end else begin
                e = exp_q.pop_front();
                if (d_out !== e.d || sindrome !== e.s || corregido !== e.c) begin
                    n_errors++;
                    $display("FAIL word: got d=%b s=%b c=%b, expected d=%b s=%b c=%b",
                             d_out, sindrome, corregido, e.d, e.s, e.c);
                end
            end
        end
    end

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[3] ^ d[2] ^ d[1], d[0],
                d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift a 7-bit codeword out MSB first with up to gap_max idle cycles per bit
    task automatic send_bits(input logic [6:0] m, input int nbits, input int gap_max);
        logic [6:0] mm;
        mm = m;
        for (int i = 6; i > 6 - nbits; i--) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                rx_valid = 1'b0;
                rx_sof   = 1'b0;
                repeat (g) tick();
            end
            rx_valid = 1'b1;
            rx_sof   = (i == 6);
            rx_bit   = mm[i];
            tick();
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
    endtask

    // Encode a nibble, inject 0/1/2 bit errors, record the expected delivery
    task automatic send_word(input logic [3:0] d, input int nerr, input int gap_max);
        logic [6:0] m, c;
        int k1, k2, s;
        exp_t e;
        m  = encode(d);
        k1 = $urandom_range(6, 0);
        k2 = (k1 + 1 + $urandom_range(5, 0)) % 7;
        e.d = d; e.s = 3'd0; e.c = 1'b0;
        if (nerr == 1) begin
            m   = m ^ (7'd1 << k1);
            e.s = 3'(k1 + 1);
            e.c = 1'b1;
        end else if (nerr == 2) begin
            m   = m ^ (7'd1 << k1) ^ (7'd1 << k2);
            s   = (k1 + 1) ^ (k2 + 1);
            c   = m ^ (7'd1 << (s - 1));
            e.d = {c[6], c[5], c[4], c[2]};
            e.s = 3'(s);
            e.c = 1'b1;
        end
        if (nerr != 0 && exp_err < 255) exp_err++;
        exp_q.push_back(e);
        send_bits(m, 7, gap_max);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        int vcnt;
        rst_n = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_d_out", int'(d_out), 0);
        check("reset_err_count", int'(err_count), 0);
        check("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Clean frame, out_valid for a single cycle
        e.d = 4'b1011; e.s = 3'd0; e.c = 1'b0;
        exp_q.push_back(e);
        send_bits(7'b1010101, 7, 0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("clean_valid_cycles", vcnt, 1);
        check("clean_err_count", int'(err_count), 0);
        drain("clean_drain");

        // Single error on m[4]
        e.d = 4'b1011; e.s = 3'b101; e.c = 1'b1;
        exp_q.push_back(e);
        exp_err = 1;
        send_bits(7'b1000101, 7, 0);
        drain("single_drain");
        check("single_err_count", int'(err_count), 1);

        // Restart after 3 bits
        send_bits(7'b1100000, 3, 0);
        e.d = 4'b1011; e.s = 3'd0; e.c = 1'b0;
        exp_q.push_back(e);
        send_bits(7'b1010101, 7, 0);
        drain("restart_drain");
        check("restart_overflow", int'(overflow), 0);

        // Backpressure: second back-to-back frame dropped
        out_ready = 1'b0;
        e.d = 4'b1011; e.s = 3'd0; e.c = 1'b0;
        exp_q.push_back(e);
        send_bits(7'b1010101, 7, 0);
        send_bits(encode(4'b0110), 7, 0);
        repeat (4) tick();
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_d_out_held", int'(d_out), 11);
        check("bp_overflow", int'(overflow), 1);
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_out_valid_cleared", int'(out_valid), 0);

        // Random frames with gaps and 0/1/2-bit errors
        for (int i = 0; i < 40; i++) begin
            send_word(4'($urandom_range(15, 0)), $urandom_range(2, 0),
                      (i % 2 == 0) ? 0 : 2);
        end
        drain("rand_drain");
        check("rand_err_count", int'(err_count), exp_err);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            send_word(4'($urandom_range(15, 0)), 1, 0);
        end
        drain("sat_drain");
        check("sat_err_count", int'(err_count), 255);

        // Reset in mid-frame
        send_bits(7'b1011000, 4, 0);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_err_count", int'(err_count), 0);
        check("midrst_d_out", int'(d_out), 0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_err = 0;
        e.d = 4'b0000; e.s = 3'd0; e.c = 1'b0;
        exp_q.push_back(e);
        send_bits(7'b0000000, 7, 0);
        drain("zero_drain");
        check("zero_err_count", int'(err_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
